universal_shift_reg: RTL and testbench

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/shift_pkg.sv | 31 +++
 rtl/shift_step.sv | 54 +++++
 rtl/universal_shift_reg.sv | 128 ++++++++++++
 tb/tb_universal_shift_reg.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared types for the universal shift register:
//   shift_op_e  - 3-bit operation codes presented on the op input
//   state_e     - controller states (IDLE / SHIFT)
//   is_shift_op - true for the ops that run through the multi-cycle SHIFT state
// -----------------------------------------------------------------------------
package shift_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_SHR  = 3'd1,
    OP_SHL  = 3'd2,
    OP_LOAD = 3'd3,
    OP_ROR  = 3'd4,
    OP_ROL  = 3'd5,
    OP_ASR  = 3'd6,
    OP_CLR  = 3'd7
  } shift_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift_op(input shift_op_e op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) ||
           (op == OP_ROL) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Purely combinational single-step shifter.
// Ports:
//   op       - operation (shift_op_e); non-shift ops pass q through
//   q        - current register value
//   fill     - bit entering at the vacated end for SHR/SHL
//   q_nxt    - value after one step
//   out_bit  - bit leaving the register on this step
// -----------------------------------------------------------------------------
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  shift_op_e        op,
  input  logic [WIDTH-1:0] q,
  input  logic             fill,
  output logic [WIDTH-1:0] q_nxt,
  output logic             out_bit
);

  always_comb begin
    q_nxt   = q;
    out_bit = 1'b0;
    case (op)
      OP_SHR: begin
        q_nxt   = {fill, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_SHL: begin
        q_nxt   = {q[WIDTH-2:0], fill};
        out_bit = q[WIDTH-1];
      end
      OP_ROR: begin
        q_nxt   = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_ROL: begin
        q_nxt   = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      OP_ASR: begin
        q_nxt   = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      default: begin
        q_nxt   = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
// Multi-cycle universal shift register. HOLD/LOAD/CLR complete in one edge;
// shift/rotate ops step one bit per clock for amt cycles.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   op          - operation code (shift_pkg::shift_op_e), sampled on accepted start
//   start       - request strobe, accepted only while not busy
//   amt         - number of single-bit steps, sampled on accepted start
//   par_in      - parallel load data
//   serial_in   - SHR/SHL fill bit, sampled on every step
//   q           - register contents
//   serial_out  - last bit shifted/rotated out
//   busy        - high while stepping
//   done        - one-cycle completion pulse
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; single-edge ops execute here
// ST_SHIFT | stepping op_r once per edge until cnt reaches zero
// -----------------------------------------------------------------------------
module universal_shift_reg
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic [CNT_W-1:0] amt,
  input  logic [WIDTH-1:0] par_in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  if (WIDTH < 2) begin : g_width_check
    $error("universal_shift_reg: WIDTH must be at least 2");
  end

  state_e           state, state_nxt;
  shift_op_e        op_r, op_r_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic             so_r, so_nxt;
  logic             done_r, done_nxt;

  logic [WIDTH-1:0] step_q;
  logic             step_out;
  shift_op_e        op_in;

  assign op_in = shift_op_e'(op);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_r),
    .q       (q_r),
    .fill    (serial_in),
    .q_nxt   (step_q),
    .out_bit (step_out)
  );

  always_comb begin
    state_nxt = state;
    op_r_nxt  = op_r;
    cnt_nxt   = cnt;
    q_nxt     = q_r;
    so_nxt    = so_r;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (op_in == OP_LOAD) begin
            q_nxt    = par_in;
            done_nxt = 1'b1;
          end else if (op_in == OP_CLR) begin
            q_nxt    = '0;
            done_nxt = 1'b1;
          end else if (!is_shift_op(op_in) || amt == '0) begin
            // HOLD, or a shift of zero steps: nothing moves, just acknowledge
            done_nxt = 1'b1;
          end else begin
            op_r_nxt  = op_in;
            cnt_nxt   = amt;
            state_nxt = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        q_nxt   = step_q;
        so_nxt  = step_out;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_r   <= OP_HOLD;
      cnt    <= '0;
      q_r    <= '0;
      so_r   <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      op_r   <= op_r_nxt;
      cnt    <= cnt_nxt;
      q_r    <= q_nxt;
      so_r   <= so_nxt;
      done_r <= done_nxt;
    end
  end

  assign q          = q_r;
  assign serial_out = so_r;
  assign busy       = (state == ST_SHIFT);
  assign done       = done_r;

endmodule

// File: tb/tb_universal_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_reg
// Directed bench for universal_shift_reg at WIDTH=8. Inputs change and outputs
// are sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_universal_shift_reg;
  import shift_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       op = 3'd0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] amt = '0;
  logic [WIDTH-1:0] par_in = '0;
  logic             serial_in = 1'b0;
  logic [WIDTH-1:0] q;
  logic             serial_out;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .start      (start),
    .amt        (amt),
    .par_in     (par_in),
    .serial_in  (serial_in),
    .q          (q),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one start for a single cycle; returns on the falling edge after
  // the accepting rising edge.
  task automatic issue(input logic [2:0] o, input int a, input logic [7:0] p, input logic si);
    @(negedge clk);
    op        = o;
    amt       = a[CNT_W-1:0];
    par_in    = p;
    serial_in = si;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done, counting busy cycles and watching for overlap.
  // Returns on the falling edge where done is high.
  task automatic wait_done(input string tag, input int exp_busy);
    int  nb;
    bit  seen;
    bit  overlap;
    nb = 0; seen = 0; overlap = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (busy && done) overlap = 1;
      if (done) seen = 1;
      else begin
        if (busy) nb++;
        @(negedge clk);
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
    check({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
  endtask

  task automatic finish_op(input string tag, input logic [7:0] exp_q, input logic exp_so);
    check({tag, "_q"}, 32'(q), 32'(exp_q));
    check({tag, "_serial_out"}, 32'(serial_out), 32'(exp_so));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_q", 32'(q), 32'h00);
    check("rst_so", 32'(serial_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // LOAD A5, then SHR 3 with serial_in=1: D2, E9, F4
    issue(OP_LOAD, 0, 8'hA5, 1'b0);
    wait_done("load_a5", 0);
    finish_op("load_a5", 8'hA5, 1'b0);
    issue(OP_SHR, 3, 8'h00, 1'b1);
    check("shr3_q_at_start", 32'(q), 32'hA5);
    check("shr3_busy_at_start", 32'(busy), 32'd1);
    @(negedge clk);
    check("shr3_step1", 32'(q), 32'hD2);
    @(negedge clk);
    check("shr3_step2", 32'(q), 32'hE9);
    @(negedge clk);
    check("shr3_step3", 32'(q), 32'hF4);
    check("shr3_done", 32'(done), 32'd1);
    check("shr3_busy_end", 32'(busy), 32'd0);
    finish_op("shr3", 8'hF4, 1'b1);

    // SHR 2 on F4 with serial_in=0, CLR attempted while busy is ignored
    issue(OP_SHR, 2, 8'h00, 1'b0);
    op     = OP_CLR;
    amt    = 4'd7;
    par_in = 8'hFF;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_clr_q_mid", 32'(q), 32'h7A);
    wait_done("busy_clr", 1);
    finish_op("busy_clr", 8'h3D, 1'b0);

    // zero-count shift
    issue(OP_SHR, 0, 8'h00, 1'b1);
    wait_done("shr0", 0);
    finish_op("shr0", 8'h3D, 1'b0);

    // full-period ROL and wrapping ROR
    issue(OP_LOAD, 0, 8'h81, 1'b0);
    wait_done("load_81", 0);
    finish_op("load_81", 8'h81, 1'b0);
    issue(OP_ROL, 8, 8'h00, 1'b0);
    wait_done("rol8", 8);
    finish_op("rol8", 8'h81, 1'b1);
    issue(OP_ROR, 9, 8'h00, 1'b0);
    wait_done("ror9", 9);
    finish_op("ror9", 8'hC0, 1'b1);

    // HOLD / CLR / LOAD leave serial_out alone
    issue(OP_HOLD, 5, 8'h55, 1'b0);
    wait_done("hold", 0);
    finish_op("hold", 8'hC0, 1'b1);
    issue(OP_CLR, 5, 8'h55, 1'b0);
    wait_done("clr", 0);
    finish_op("clr", 8'h00, 1'b1);
    issue(OP_LOAD, 3, 8'h80, 1'b0);
    wait_done("load_80", 0);
    finish_op("load_80", 8'h80, 1'b1);

    // ASR and saturating SHL
    issue(OP_ASR, 2, 8'h00, 1'b1);
    wait_done("asr2", 2);
    finish_op("asr2", 8'hE0, 1'b0);
    issue(OP_SHL, 15, 8'h00, 1'b0);
    wait_done("shl15", 15);
    finish_op("shl15", 8'h00, 1'b0);

    // reset in the middle of ROR 5, then LOAD 3C on the first edge after release
    issue(OP_LOAD, 0, 8'hA5, 1'b0);
    wait_done("load_a5_2", 0);
    finish_op("load_a5_2", 8'hA5, 1'b0);
    serial_out_prime: begin
      issue(OP_ROR, 5, 8'h00, 1'b0);
      check("ror5_busy", 32'(busy), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_q", 32'(q), 32'h00);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_so", 32'(serial_out), 32'd0);
    end
    @(negedge clk);
    check("midrst_done_hold", 32'(done), 32'd0);
    op     = OP_LOAD;
    par_in = 8'h3C;
    amt    = '0;
    start  = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("post_rst_load_q", 32'(q), 32'h3C);
    check("post_rst_load_done", 32'(done), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("post_rst_done_clear", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
